line_fill_memory: RTL
=====================

# line_fill_memory

Backing-store responder for the 4-way set-associative cache's line-fill interface. It accepts a line request (the cache's `ask_for_data` strobe plus a 32-bit byte address), waits a fixed access latency, then returns a full 512-bit line with a one-cycle valid strobe. The block sits below the cache in the memory hierarchy and is the other end of the cache's refill path. An optional write path accepts full-line writes for write-back and bench preload.

## Interface
- `DEPTH`, 256: number of 512-bit lines; power of two, 2..65536; `IDX_W = log2(DEPTH)`.
- `LATENCY`, 4: cycles from request acceptance to completion; legal range 1..255.
- `clk  in  1`: clock; all logic is rising-edge.
- `rst  in  1`: asynchronous, active-low reset.
- `req  in  1`: request strobe; connects to the cache's `ask_for_data`.
- `address  in  32`: byte address; line index = `address[6+IDX_W-1:6]`; bits [5:0] and bits above the index are ignored.
- `wr_en  in  1`: with `req`, selects a line write instead of a read.
- `wr_data  in  512`: write line, sampled with `req`.
- `busy  out  1`: high while an operation is in flight.
- `data_valid  out  1`: one-cycle pulse; `data` holds the read line.
- `data  out  512`: read line; holds its value until the next read completes.
- `wr_ack  out  1`: one-cycle pulse when a write commits.
- `drop_cnt  out  8`: saturating count of requests ignored while busy.

## Operation
- Storage is `DEPTH` x 512-bit lines and is not cleared by reset.
- Simulation-start contents: for line i, every 32-bit word equals i zero-extended (16 identical words).
- FSM states:
  - IDLE: if `req` is sampled high, capture the index, `wr_en` and `wr_data`; load `cnt <= LATENCY-1`; set `busy <= 1`; go to WAIT.
  - WAIT: if `cnt != 0`, `cnt <= cnt-1`. If `cnt == 0`, complete the operation, set `busy <= 0`, and go to IDLE.
- Read completion: `data <= line[idx]` and `data_valid <= 1` for one cycle.
- Write completion: `line[idx] <= wr_data` (captured value) and `wr_ack <= 1` for one cycle.
- Inputs are captured at acceptance. Changes to `address`, `wr_data` or `wr_en` during WAIT have no effect.
- Drop counting:
  - A registered copy of `req` gives a rising edge (`req & ~req_q`).
  - A rising edge seen in WAIT increments `drop_cnt`, saturating at 255.
  - A `req` held high across an operation does not count as a drop.
- Simultaneous events:
  - A request in the same cycle a completion pulse is driven is in IDLE and is accepted.
  - `req` held high continuously yields one operation every `LATENCY+1` cycles.
- Reset values: `busy=0`, `data_valid=0`, `data=0`, `wr_ack=0`, `drop_cnt=0`, state IDLE, `cnt=0`, `req_q=0`.
- Reset mid-operation abandons the operation. A pending write is not committed and no pulse is emitted.

## Timing
- Request sampled at edge T: `busy` is high after edge T.
- Completion at edge T+LATENCY: `busy` falls, and `data_valid` or `wr_ack` is high for the cycle after edge T+LATENCY.
- Next accept is at edge T+LATENCY+1 at the earliest.
- Read-after-write to the same line, issued back-to-back, returns the new data.
- `data` is registered; there is no combinational path from `address` to `data`.

## Configuration
- `LINE_FILL_MEM_WRITE_EN` defined: the write path behaves as described above.
- `LINE_FILL_MEM_WRITE_EN` undefined:
  - `wr_en` and `wr_data` are ignored, and every request is a read.
  - `wr_ack` is tied to 0.
  - Storage is read-only after initialization.

## Test plan
- Reset: with `rst=0`, all outputs are 0. After release with `req=0` for 10 cycles, `busy=0` and there are no pulses.
- Default read: `LATENCY=4`, one-cycle `req`, `address=32'h0000_0A40` (index 41) at edge T -> `busy` high for edges T..T+3, `data_valid` after T+4, `data` = 16 words of 32'h29.
- Write then read (macro defined): write `{16{32'hDEADBEEF}}` to index 7 -> `wr_ack` after T+4. A read of index 7 accepted at T+5 -> `data_valid` after T+9 with the written line.
- Drops:
  - Pulse `req` three times during one operation -> `drop_cnt=3`, with one completion only.
  - 300 pulses -> `drop_cnt=255`.
- Reset at edge T+2 of a write -> after release, a read of the same index returns the original initialization pattern, with no `wr_ack`.
- `LATENCY=1` with `req` held high -> `data_valid` every 2 cycles. Without the macro and with `wr_en=1`, reads still occur and `wr_ack=0`.

Source files
------------

// File: rtl/line_fill_memory_if.sv
// line_fill_memory_if: refill-path bundle between the cache (master) and the
// line_fill_memory backing store (slave).
interface line_fill_memory_if;
    logic         req;
    logic [31:0]  address;
    logic         wr_en;
    logic [511:0] wr_data;
    logic         busy;
    logic         data_valid;
    logic [511:0] data;
    logic         wr_ack;
    logic [7:0]   drop_cnt;

    modport master (
        output req, address, wr_en, wr_data,
        input  busy, data_valid, data, wr_ack, drop_cnt
    );

    modport slave (
        input  req, address, wr_en, wr_data,
        output busy, data_valid, data, wr_ack, drop_cnt
    );
endinterface

// File: rtl/line_fill_memory.sv
// line_fill_memory: fixed-latency 512-bit line responder for the cache refill path.
// Define LINE_FILL_MEM_WRITE_EN to enable the full-line write path; otherwise storage is read-only.
module line_fill_memory #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input logic               clk,
    input logic               rst,
    line_fill_memory_if.slave bus
);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Power-on pattern: every 32-bit word of line i holds i.
    function automatic logic [511:0] init_line(input logic [IDX_W-1:0] i);
        logic [31:0] word_v;
        word_v = {{(32-IDX_W){1'b0}}, i};
        return {16{word_v}};
    endfunction

    state_t           state_r;
    state_t           state_nx_s;
    logic [7:0]       cnt_r;
    logic [7:0]       cnt_nx_s;
    logic             busy_r;
    logic             busy_nx_s;
    logic             data_valid_r;
    logic             data_valid_nx_s;
    logic             wr_ack_r;
    logic             wr_ack_nx_s;
    logic [7:0]       drop_cnt_r;
    logic [7:0]       drop_cnt_nx_s;
    logic [511:0]     data_r;
    logic [511:0]     data_nx_s;
    logic             req_q_r;
    logic [IDX_W-1:0] idx_r;
    logic             wr_en_r;
    logic             accept_s;
    logic             commit_s;
    logic             rise_s;
    logic             wr_en_cap_s;
    logic [511:0]     line_rd_s;
    logic             unused_s;

    assign rise_s = bus.req & ~req_q_r;

`ifdef LINE_FILL_MEM_WRITE_EN
    logic [511:0] wr_data_r;
    logic [511:0] line_arr_s [DEPTH];

    assign wr_en_cap_s = bus.wr_en;

    // Write payload is a pure capture register; it only matters while an op is in flight.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            wr_data_r <= bus.wr_data;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_line
        logic [511:0] line_r = init_line(IDX_W'(g));

        // Line storage is deliberately outside reset so contents survive rst.
        always_ff @(posedge clk) begin
            if (commit_s && (idx_r == IDX_W'(g))) begin
                line_r <= wr_data_r;
            end
        end

        assign line_arr_s[g] = line_r;
    end

    assign line_rd_s = line_arr_s[idx_r];
    assign unused_s  = ^{bus.address[5:0], bus.address[31:6+IDX_W]};
`else
    // Read-only storage never changes, so the contents are the init pattern itself.
    assign wr_en_cap_s = 1'b0;
    assign line_rd_s   = init_line(idx_r);
    assign unused_s    = ^{bus.address[5:0], bus.address[31:6+IDX_W], bus.wr_en, bus.wr_data};
`endif

    // Next-state and output decode for the accept/wait/complete sequence.
    always_comb begin
        state_nx_s      = state_r;
        cnt_nx_s        = cnt_r;
        busy_nx_s       = busy_r;
        data_valid_nx_s = 1'b0;
        wr_ack_nx_s     = 1'b0;
        drop_cnt_nx_s   = drop_cnt_r;
        data_nx_s       = data_r;
        accept_s        = 1'b0;
        commit_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.req) begin
                    accept_s   = 1'b1;
                    cnt_nx_s   = CNT_LOAD;
                    busy_nx_s  = 1'b1;
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Only a fresh rising edge is a drop; a req held through the op is not.
                if (rise_s && (drop_cnt_r != 8'hFF)) begin
                    drop_cnt_nx_s = drop_cnt_r + 8'd1;
                end else begin
                    drop_cnt_nx_s = drop_cnt_r;
                end

                if (cnt_r != 8'd0) begin
                    cnt_nx_s = cnt_r - 8'd1;
                end else begin
                    busy_nx_s  = 1'b0;
                    state_nx_s = ST_IDLE;
                    if (wr_en_r) begin
                        commit_s    = 1'b1;
                        wr_ack_nx_s = 1'b1;
                    end else begin
                        data_valid_nx_s = 1'b1;
                        data_nx_s       = line_rd_s;
                    end
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // Control, output and request-capture registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 8'd0;
            busy_r       <= 1'b0;
            data_valid_r <= 1'b0;
            wr_ack_r     <= 1'b0;
            drop_cnt_r   <= 8'd0;
            data_r       <= 512'd0;
            req_q_r      <= 1'b0;
            idx_r        <= '0;
            wr_en_r      <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            busy_r       <= busy_nx_s;
            data_valid_r <= data_valid_nx_s;
            wr_ack_r     <= wr_ack_nx_s;
            drop_cnt_r   <= drop_cnt_nx_s;
            data_r       <= data_nx_s;
            req_q_r      <= bus.req;
            if (accept_s) begin
                idx_r   <= bus.address[6+IDX_W-1:6];
                wr_en_r <= wr_en_cap_s;
            end
        end
    end

    assign bus.busy       = busy_r;
    assign bus.data_valid = data_valid_r;
    assign bus.data       = data_r;
    assign bus.wr_ack     = wr_ack_r;
    assign bus.drop_cnt   = drop_cnt_r;
endmodule
